spi_slave_rx_tx: RTL and testbench

Synthesizable SPI slave (mode 3: CPOL=1, CPHA=1, MSB first) that is the downstream consumer of the DPI SPI master model's spi_cs/spi_clk/spi_mosi and produces its spi_miso.
- Oversamples all SPI pins in the sys_clk domain.
- Deserializes MOSI into bytes delivered on a valid-pulse interface.
- Serializes bytes from a one-entry ready/valid TX holding buffer onto MISO.

---
 rtl/spi_slave_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_rx_tx.sv | 184 ++++++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI mode-3 slave.
package spi_slave_pkg;

  localparam int         DATA_W_DEF    = 8;
  localparam logic [7:0] IDLE_FILL_DEF = 8'hFF;

  // SPI mode 3: clock idles high, data captured on the rising edge.
  localparam logic CPOL = 1'b1;
  localparam logic CPHA = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with a delay flop
// behind it so single-cycle rise/fall pulses can be derived in sys_clk.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic in_pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Shift the pin through the synchronizer chain, then one extra delay flop.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_pin};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-3 slave: oversampled pins, MOSI deserializer with valid pulse,
// MISO serializer fed from a one-entry ready/valid holding buffer.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | CS high; SPI clock ignored, MISO released (oe=0, level 1)
// SHIFT | CS low; capture MOSI on SCLK rise, drive MISO on SCLK fall
module spi_slave_rx_tx
  import spi_slave_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [DATA_W-1:0] IDLE_FILL   = DATA_W'(IDLE_FILL_DEF)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_clk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              frame_start,
  output logic              frame_end,
  output logic              frame_abort
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level_unused, cs_rise, cs_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_pin    (spi_clk_i),
    .level     (sclk_level_unused),
    .rise      (sclk_rise),
    .fall      (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_pin    (spi_cs_i),
    .level     (cs_level_unused),
    .rise      (cs_rise),
    .fall      (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_pin    (spi_mosi_i),
    .level     (mosi_level),
    .rise      (mosi_rise_unused),
    .fall      (mosi_fall_unused)
  );

  state_e            state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] hold_q;
  logic              full_q;

  logic              frame_go;
  logic              word_done;
  logic              load;
  logic              tx_hs;
  logic [DATA_W-1:0] load_val;
  logic              load_underrun;

  assign tx_ready  = ~full_q;
  assign tx_hs     = tx_valid & ~full_q;
  assign frame_go  = (state_q == IDLE) && cs_fall;
  // CS activity in the same cycle masks any SCLK edge.
  assign word_done = (state_q == SHIFT) && !cs_rise && !cs_fall &&
                     sclk_rise && (bit_cnt_q == LAST_BIT);
  assign load      = frame_go || word_done;

  // Next transmit word: buffered word, else same-cycle bypass, else fill.
  always_comb begin
    load_val      = IDLE_FILL;
    load_underrun = 1'b0;
    if (full_q) begin
      load_val = hold_q;
    end else if (tx_valid) begin
      load_val = tx_data;
    end else begin
      load_underrun = 1'b1;
    end
  end

  // One-entry TX holding buffer; a bypass load never writes it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else if (load) begin
      if (full_q) begin
        full_q <= tx_hs;
        if (tx_hs) hold_q <= tx_data;
      end
    end else if (tx_hs) begin
      hold_q <= tx_data;
      full_q <= 1'b1;
    end
  end

  // Frame FSM, shift registers, MISO driver and status pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
      spi_miso_o  <= 1'b1;
      spi_miso_oe <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q     <= SHIFT;
            frame_start <= 1'b1;
            bit_cnt_q   <= '0;
            tx_shift_q  <= load_val;
            tx_underrun <= load_underrun;
            spi_miso_o  <= load_val[DATA_W-1];
            spi_miso_oe <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q     <= IDLE;
            frame_end   <= 1'b1;
            frame_abort <= (bit_cnt_q != '0);
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            spi_miso_o  <= 1'b1;
            spi_miso_oe <= 1'b0;
          end else if (!cs_fall) begin
            if (sclk_fall) begin
              spi_miso_o <= tx_shift_q[DATA_W-1];
            end
            if (sclk_rise) begin
              rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_level};
              if (bit_cnt_q == LAST_BIT) begin
                rx_data     <= {rx_shift_q[DATA_W-2:0], mosi_level};
                rx_valid    <= 1'b1;
                bit_cnt_q   <= '0;
                tx_shift_q  <= load_val;
                tx_underrun <= load_underrun;
              end else begin
                tx_shift_q <= tx_shift_q << 1;
                bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Bench for spi_slave_rx_tx: a behavioural mode-3 master drives the pins,
// expected RX/MISO bytes are queued at stimulus time and popped on output.
module tb_spi_slave_rx_tx;

  localparam int HALF = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       spi_clk_i, spi_cs_i, spi_mosi_i;
  logic       spi_miso_o, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_underrun, frame_start, frame_end, frame_abort;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_end = 0, n_abort = 0, n_under = 0;
  int s_start, s_end, s_abort, s_under;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_mi[$];

  spi_slave_rx_tx dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .spi_clk_i   (spi_clk_i),
    .spi_cs_i    (spi_cs_i),
    .spi_mosi_i  (spi_mosi_i),
    .spi_miso_o  (spi_miso_o),
    .spi_miso_oe (spi_miso_oe),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_underrun (tx_underrun),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_abort (frame_abort)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1, "timeout");
  end

  // Monitor: count pulses and check every received word against the queue.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (frame_start) n_start++;
      if (frame_end)   n_end++;
      if (frame_abort) n_abort++;
      if (tx_underrun) n_under++;
      if (rx_valid) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got %h, nothing expected", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_rx.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL rx_data: got %h expected %h", rx_data, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    s_start = n_start; s_end = n_end; s_abort = n_abort; s_under = n_under;
  endtask

  task automatic check_deltas(input string tag, input int ds, input int de, input int da, input int du);
    check({tag, "_frame_start"}, n_start - s_start, ds);
    check({tag, "_frame_end"},   n_end - s_end,     de);
    check({tag, "_frame_abort"}, n_abort - s_abort, da);
    check({tag, "_tx_underrun"}, n_under - s_under, du);
  endtask

  task automatic preload(input logic [7:0] d);
    @(negedge sys_clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
  endtask

  // One SCLK period: fall (drive MOSI), then rise (sample MISO).
  task automatic spi_bit(input logic mo, output logic mi);
    spi_clk_i  = 1'b0;
    spi_mosi_i = mo;
    repeat (HALF) @(negedge sys_clk);
    spi_clk_i = 1'b1;
    mi = spi_miso_o;
    repeat (HALF) @(negedge sys_clk);
  endtask

  // One byte; optionally offers inj_d on tx_valid for exactly the cycle
  // in which the slave sees the last rising edge (pin edge + 3 cycles).
  task automatic spi_byte(input logic [7:0] mo, input bit inject, input logic [7:0] inj_d);
    logic [7:0] got;
    logic [7:0] e;
    for (int i = 7; i >= 0; i--) begin
      if (inject && i == 0) begin
        spi_clk_i  = 1'b0;
        spi_mosi_i = mo[i];
        repeat (HALF) @(negedge sys_clk);
        spi_clk_i = 1'b1;
        got[i] = spi_miso_o;
        repeat (2) @(negedge sys_clk);
        tx_data  = inj_d;
        tx_valid = 1'b1;
        @(negedge sys_clk);
        tx_valid = 1'b0;
        repeat (HALF - 3) @(negedge sys_clk);
      end else begin
        spi_bit(mo[i], got[i]);
      end
    end
    checks++;
    if (exp_mi.size() == 0) begin
      errors++;
      $display("FAIL miso_unexpected: got %h, nothing expected", got);
    end else begin
      e = exp_mi.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL miso_byte: got %h expected %h", got, e);
      end
    end
  endtask

  task automatic frame_begin();
    spi_cs_i = 1'b0;
    repeat (HALF) @(negedge sys_clk);
  endtask

  task automatic frame_finish();
    repeat (HALF) @(negedge sys_clk);
    spi_cs_i = 1'b1;
    repeat (2 * HALF) @(negedge sys_clk);
  endtask

  initial begin
    logic dummy;
    sys_rst_n  = 1'b0;
    spi_clk_i  = 1'b1;
    spi_cs_i   = 1'b1;
    spi_mosi_i = 1'b0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("rst_miso", spi_miso_o, 1);
    check("rst_miso_oe", spi_miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 8'h00);
    sys_rst_n = 1'b1;

    // Idle pins for 100 cycles.
    snap();
    repeat (100) @(negedge sys_clk);
    check_deltas("idle", 0, 0, 0, 0);
    check("idle_miso_oe", spi_miso_oe, 0);
    check("idle_miso", spi_miso_o, 1);

    // Single byte with preloaded TX word.
    preload(8'hA5);
    check("preload_tx_ready", tx_ready, 0);
    snap();
    exp_rx.push_back(8'h3C);
    exp_mi.push_back(8'hA5);
    frame_begin();
    check("frame_miso_oe", spi_miso_oe, 1);
    spi_byte(8'h3C, 0, 8'h00);
    frame_finish();
    check_deltas("byte1", 1, 1, 0, 1);
    check("byte1_tx_ready", tx_ready, 1);
    check("byte1_miso_oe", spi_miso_oe, 0);

    // Two bytes, one TX word: second word is the idle fill.
    preload(8'h55);
    snap();
    exp_rx.push_back(8'h01); exp_rx.push_back(8'hFE);
    exp_mi.push_back(8'h55); exp_mi.push_back(8'hFF);
    frame_begin();
    spi_byte(8'h01, 0, 8'h00);
    spi_byte(8'hFE, 0, 8'h00);
    frame_finish();
    check_deltas("two", 1, 1, 0, 2);

    // Bypass on the word boundary with the buffer empty.
    preload(8'h11);
    snap();
    exp_rx.push_back(8'hAA); exp_rx.push_back(8'h5A);
    exp_mi.push_back(8'h11); exp_mi.push_back(8'h96);
    frame_begin();
    spi_byte(8'hAA, 1, 8'h96);
    check("bypass_no_underrun", n_under - s_under, 0);
    check("bypass_tx_ready", tx_ready, 1);
    spi_byte(8'h5A, 0, 8'h00);
    frame_finish();
    check_deltas("bypass", 1, 1, 0, 1);

    // Aborted frame after 5 bits, then a clean frame.
    snap();
    frame_begin();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, dummy);
    frame_finish();
    check_deltas("abort", 1, 1, 1, 1);
    snap();
    exp_rx.push_back(8'hC3);
    exp_mi.push_back(8'hFF);
    frame_begin();
    spi_byte(8'hC3, 0, 8'h00);
    frame_finish();
    check_deltas("after_abort", 1, 1, 0, 2);

    // Asynchronous reset in the middle of a byte.
    frame_begin();
    for (int i = 0; i < 4; i++) spi_bit(i[0], dummy);
    snap();
    sys_rst_n = 1'b0;
    #1;
    check("arst_miso_oe", spi_miso_oe, 0);
    check("arst_miso", spi_miso_o, 1);
    check("arst_tx_ready", tx_ready, 1);
    check("arst_rx_data", rx_data, 8'h00);
    @(negedge sys_clk);
    spi_cs_i  = 1'b1;
    spi_clk_i = 1'b1;
    repeat (10) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    check_deltas("arst_quiet", 0, 0, 0, 0);
    snap();
    exp_rx.push_back(8'h7E);
    exp_mi.push_back(8'hFF);
    frame_begin();
    spi_byte(8'h7E, 0, 8'h00);
    frame_finish();
    check_deltas("post_rst", 1, 1, 0, 2);

    check("rx_queue_drained", exp_rx.size(), 0);
    check("miso_queue_drained", exp_mi.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
